fft32_stage2: RTL and testbench
===============================

# fft32_stage2

Second stage of the 32-point radix-2 DIF single-path delay-feedback (SDF) FFT pipeline. It sits directly downstream of `STAGE1` and consumes its `valid_o` / `data_out_r` / `data_out_i` stream unchanged. Each stage-1-ordered frame of 32 complex samples is split into two 16-sample groups. For each group the block runs an 8-deep delay line, butterfly and W16^k twiddle multiply, then feeds stage 3 in the same streaming format.

## Interface
- `DATA_W`, 19, sample width per real/imag component, two's complement
- `TW_W`, 10, twiddle component width, signed Q1.8 (1.0 = 256)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  input sample valid (connect `STAGE1.valid_o`)
- `data_in_r`  in  19  input real part
- `data_in_i`  in  19  input imag part
- `valid_o`  out  1  output sample valid
- `data_out_r`  out  19  output real part
- `data_out_i`  out  19  output imag part

## Operation
- The frame counter `cnt[4:0]` advances on every *step*, where step = `valid_i | draining`.
- Phase is `cnt[3]`. The delay-line slot is `cnt[2:0]`.
- Phase 0 (fill/emit):
  - the input is written to the delay line;
  - the previous group's stored difference `d[k]`, k = `cnt[2:0]`, is emitted as `d[k]·W16^k`;
  - this emission exists only if that group's butterflies have completed (`pending` flag).
- Phase 1 (butterfly):
  - with `a` = delay-line slot and `b` = input, `a+b` is emitted and `a−b` is written back to the same slot;
  - `pending` is set at `cnt[3:0]==15`.
- Drain: FSM states IDLE, RUN, DRAIN.
  - RUN→DRAIN when `cnt` wraps 31→0 and `valid_i`=0 on the next cycle.
  - DRAIN steps 8 times without input, emitting group-1 differences, then → IDLE.
  - RUN→RUN on back-to-back frames: the new frame's first half is stored while the old differences are emitted.
- A new frame arrives either back-to-back or in IDLE. A `valid_i` pulse in DRAIN at slot ≠ 0 is a protocol violation, behaviour undefined and not tested. A `valid_i` pulse at DRAIN slot 0 is treated as back-to-back.
- Mid-frame `valid_i` gaps stall everything: counter, delay line and output generation.
- Twiddles W16^k = (re, im) for k = 0..7, in Q1.8:
  - k0 (256, 0), k1 (237, −98), k2 (181, −181), k3 (98, −237)
  - k4 (0, −256), k5 (−98, −237), k6 (−181, −181), k7 (−237, −98)
- Sums and differences are computed at 20 bits, then saturated to 19 bits (±262143 / −262144).
- Complex multiply:
  - (ac−bd) and (ad+bc) are formed at full precision;
  - round by +128, then arithmetic shift right 8;
  - saturate to 19 bits.
- Output order per group: 8 sums (k = 0..7), then 8 twiddled differences (k = 0..7).

## Timing
- Reset values: `valid_o`=0, `data_out_r`=0, `data_out_i`=0, `cnt`=0, all 8 delay-line entries 0, `pending`=0, FSM = IDLE.
- Outputs are registered. An output produced on a step appears the following cycle.
- Latency: first frame sample at cycle t gives first output (`valid_o`) at t+9. An isolated frame with gapless input produces 32 consecutive `valid_o` cycles, t+9 .. t+40.
- Reset asserted mid-frame: all state is cleared asynchronously. The partial frame is discarded. The next frame must start from IDLE.

## Structure
- Package `fft32_pkg`:
  - `DATA_W`, `TW_W`, `TW_FRAC`=8;
  - the 8-entry W16 twiddle constant table;
  - a saturate-to-`DATA_W` function (shared with the other stages).
- Sub-module `fft32_cmul`: combinational complex multiply with round and saturate, reused by stages 1, 3 and 4.
- The delay line is a register array indexed by `cnt[2:0]`, not a shift chain.

## Test plan
- Reset: hold `rst`=0 with random inputs → `valid_o`=0 and outputs 0 throughout; first output appears exactly 9 cycles after the first valid sample post-reset.
- Impulse: x0 = (1000, 0), rest 0 → output 0 = (1000, 0), output 8 = (1000, 0), all others 0; `valid_o` high for exactly 32 cycles.
- Twiddle k=1: x1 = (1000, 0), rest 0 → output 1 = (1000, 0), output 9 = (926, −383); all k = 0..7 checked against the golden model.
- Saturation: x0 = x8 = (262143, −262144) → output 0 = (262143, −262144), output 8 = (0, 0).
- Back-to-back plus stall: two random frames with a 3-cycle `valid_i` gap at sample 12 of frame 1 → `valid_o` gaps by exactly 3 cycles; both frames bit-match the golden model; no drain between frames.
- Reset mid-frame: `rst` pulse at sample 20, then a fresh impulse frame → outputs identical to the isolated impulse case.

Source files
------------

// File: rtl/fft32_pkg.sv
// fft32_pkg: shared definitions for the 32-point radix-2 DIF SDF FFT stages.
//   DATA_W / TW_W / TW_FRAC : sample width, twiddle width, twiddle fraction bits
//   SUM_W                   : one-bit-growth width for butterfly sums/differences
//   TW_RE / TW_IM           : W16^k twiddle table, k = 0..7, signed Q1.8
//   state_t                 : stage sequencing states
//   sat_dw()                : saturate a signed value to DATA_W bits
package fft32_pkg;

  localparam int DATA_W  = 19;
  localparam int TW_W    = 10;
  localparam int TW_FRAC = 8;
  localparam int SUM_W   = DATA_W + 1;

  localparam int SAT_MAX = (2 ** (DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DATA_W - 1));

  localparam logic signed [TW_W-1:0] TW_RE [8] = '{
    10'sd256,  10'sd237,  10'sd181,  10'sd98,
    10'sd0,   -10'sd98,  -10'sd181, -10'sd237
  };

  localparam logic signed [TW_W-1:0] TW_IM [8] = '{
    10'sd0,   -10'sd98,  -10'sd181, -10'sd237,
   -10'sd256, -10'sd237, -10'sd181, -10'sd98
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  function automatic logic signed [DATA_W-1:0] sat_dw(input logic signed [31:0] x);
    if (x > SAT_MAX) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (x < SAT_MIN) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fft32_cmul.sv
// fft32_cmul: combinational complex multiply y = a * w with round-half-up
// (+2^(TW_FRAC-1)), arithmetic shift by TW_FRAC and saturation to DATA_W.
//   a_r, a_i : data operand, DATA_W signed
//   w_r, w_i : twiddle operand, TW_W signed Q1.8
//   y_r, y_i : rounded, saturated product, DATA_W signed
module fft32_cmul
  import fft32_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [TW_W-1:0]   w_r,
  input  logic signed [TW_W-1:0]   w_i,
  output logic signed [DATA_W-1:0] y_r,
  output logic signed [DATA_W-1:0] y_i
);

  // Full product width plus one bit for the add/subtract of two products.
  localparam int ACC_W = DATA_W + TW_W + 1;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (TW_FRAC - 1);

  logic signed [ACC_W-1:0] acc_r, acc_i;
  logic signed [ACC_W-1:0] shr_r, shr_i;

  always_comb begin
    acc_r = ACC_W'(a_r) * ACC_W'(w_r) - ACC_W'(a_i) * ACC_W'(w_i);
    acc_i = ACC_W'(a_r) * ACC_W'(w_i) + ACC_W'(a_i) * ACC_W'(w_r);
    shr_r = (acc_r + RND) >>> TW_FRAC;
    shr_i = (acc_i + RND) >>> TW_FRAC;
    y_r   = sat_dw(32'(shr_r));
    y_i   = sat_dw(32'(shr_i));
  end

endmodule

// File: rtl/fft32_stage2.sv
// fft32_stage2: second stage of the 32-point radix-2 DIF SDF FFT.
// Each 32-sample frame is handled as two 16-sample groups through an 8-entry
// delay line: the first half of a group is stored, the second half is
// butterflied against it (sum emitted, difference stored), and the stored
// differences are emitted times W16^k while the next group is being stored.
//   clk                    : rising-edge clock
//   rst                    : asynchronous active-low reset
//   valid_i                : input sample valid
//   data_in_r / data_in_i  : input sample, DATA_W signed
//   valid_o                : output sample valid (registered)
//   data_out_r / data_out_i: output sample, DATA_W signed (registered)
module fft32_stage2
  import fft32_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_in_r,
  input  logic signed [DATA_W-1:0] data_in_i,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] data_out_r,
  output logic signed [DATA_W-1:0] data_out_i
);

  state_t                   state_q, state_d;
  logic [4:0]               cnt_q;
  logic                     pending_q;
  logic signed [DATA_W-1:0] dl_r [8];
  logic signed [DATA_W-1:0] dl_i [8];

  logic [2:0]               slot;
  logic                     phase;
  logic                     drain_step;
  logic                     step;
  logic signed [DATA_W-1:0] rd_r, rd_i;
  logic signed [TW_W-1:0]   w_r, w_i;
  logic signed [SUM_W-1:0]  sum_r, sum_i, dif_r, dif_i;
  logic signed [DATA_W-1:0] tw_r, tw_i;
  logic                     emit;
  logic signed [DATA_W-1:0] emit_r, emit_i;

  always_comb begin
    slot  = cnt_q[2:0];
    phase = cnt_q[3];
    // cnt sits at 0 in RUN only right after a frame wrap; no input there
    // means no follow-on frame, so this cycle is already the first drain step.
    drain_step = (state_q == ST_DRAIN) ||
                 ((state_q == ST_RUN) && (cnt_q == '0) && !valid_i);
    step  = valid_i || drain_step;
    rd_r  = dl_r[slot];
    rd_i  = dl_i[slot];
    w_r   = TW_RE[slot];
    w_i   = TW_IM[slot];
    sum_r = SUM_W'(rd_r) + SUM_W'(data_in_r);
    sum_i = SUM_W'(rd_i) + SUM_W'(data_in_i);
    dif_r = SUM_W'(rd_r) - SUM_W'(data_in_r);
    dif_i = SUM_W'(rd_i) - SUM_W'(data_in_i);
  end

  fft32_cmul u_cmul (
    .a_r (rd_r),
    .a_i (rd_i),
    .w_r (w_r),
    .w_i (w_i),
    .y_r (tw_r),
    .y_i (tw_i)
  );

  always_comb begin
    emit   = 1'b0;
    emit_r = tw_r;
    emit_i = tw_i;
    if (step) begin
      if (phase) begin
        emit   = 1'b1;
        emit_r = sat_dw(32'(sum_r));
        emit_i = sat_dw(32'(sum_i));
      end else if (pending_q) begin
        emit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (valid_i)         state_d = ST_RUN;
      ST_RUN:   if (drain_step)      state_d = ST_DRAIN;
      ST_DRAIN: if (slot == 3'd7)    state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        dl_r[i] <= '0;
        dl_i[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_o <= emit;
      if (emit) begin
        data_out_r <= emit_r;
        data_out_i <= emit_i;
      end
      if (step) begin
        // The last drain step returns cnt to 0 so IDLE always starts a frame at slot 0.
        cnt_q <= ((state_q == ST_DRAIN) && (slot == 3'd7)) ? '0 : cnt_q + 5'd1;
        if (cnt_q[3:0] == 4'hF) begin
          pending_q <= 1'b1;
        end else if (!phase && (slot == 3'd7)) begin
          pending_q <= 1'b0;
        end
      end
      if (valid_i) begin
        if (phase) begin
          dl_r[slot] <= sat_dw(32'(dif_r));
          dl_i[slot] <= sat_dw(32'(dif_i));
        end else begin
          dl_r[slot] <= data_in_r;
          dl_i[slot] <= data_in_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft32_stage2.sv
// tb_fft32_stage2: scoreboard bench for fft32_stage2. Frames are computed by a
// direct group-wise butterfly/twiddle model and queued; a monitor compares
// every valid output against the queue and records its cycle for timing checks.
module tb_fft32_stage2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_i = 1'b0;
  logic signed [18:0] data_in_r = '0;
  logic signed [18:0] data_in_i = '0;
  logic              valid_o;
  logic signed [18:0] data_out_r;
  logic signed [18:0] data_out_i;

  fft32_stage2 dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_r[$];
  int exp_i[$];
  int vcyc[$];
  int got_r[64];
  int got_i[64];
  int imp_r[32];
  int imp_i[32];
  int out_idx = 0;
  int fr_r[64];
  int fr_i[64];
  int mon_er, mon_ei;
  int WR[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int WI[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  function automatic int sat19(longint v);
    if (v > 262143) return 262143;
    if (v < -262144) return -262144;
    return int'(v);
  endfunction

  function automatic int tw_mul(int dr, int di, int wr, int wi, bit imag);
    longint p;
    if (imag) p = longint'(dr) * wi + longint'(di) * wr;
    else      p = longint'(dr) * wr - longint'(di) * wi;
    return sat19((p + 128) >>> 8);
  endfunction

  function automatic int rnd19();
    return int'($urandom_range(0, 524287)) - 262144;
  endfunction

  // Expected stage output for the frame at fr_*[base +: 32]:
  // per 16-sample group, 8 sums then 8 twiddled differences.
  task automatic model_push(int base);
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 8; k++) begin
        exp_r.push_back(sat19(longint'(fr_r[base+16*g+k]) + fr_r[base+16*g+8+k]));
        exp_i.push_back(sat19(longint'(fr_i[base+16*g+k]) + fr_i[base+16*g+8+k]));
      end
      for (int k = 0; k < 8; k++) begin
        int dr, di;
        dr = sat19(longint'(fr_r[base+16*g+k]) - fr_r[base+16*g+8+k]);
        di = sat19(longint'(fr_i[base+16*g+k]) - fr_i[base+16*g+8+k]);
        exp_r.push_back(tw_mul(dr, di, WR[k], WI[k], 1'b0));
        exp_i.push_back(tw_mul(dr, di, WR[k], WI[k], 1'b1));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst && valid_o) begin
      vcyc.push_back(cyc);
      if (out_idx < 64) begin
        got_r[out_idx] = int'(data_out_r);
        got_i[out_idx] = int'(data_out_i);
      end
      n_cmp++;
      if (exp_r.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output idx=%0d: got (%0d,%0d), required no output",
                 out_idx, data_out_r, data_out_i);
      end else begin
        mon_er = exp_r.pop_front();
        mon_ei = exp_i.pop_front();
        if (int'(data_out_r) != mon_er || int'(data_out_i) != mon_ei) begin
          n_bad++;
          $display("FAIL sample idx=%0d: got (%0d,%0d), required (%0d,%0d)",
                   out_idx, data_out_r, data_out_i, mon_er, mon_ei);
        end
      end
      out_idx++;
    end
  end

  task automatic clear_frames();
    for (int s = 0; s < 64; s++) begin
      fr_r[s] = 0;
      fr_i[s] = 0;
    end
  endtask

  task automatic reset_quiet(string name, int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b0 || data_out_r !== '0 || data_out_i !== '0) begin
        n_bad++;
        $display("FAIL %s cyc=%0d: got valid=%b data=(%0d,%0d), required valid=0 data=(0,0)",
                 name, c, valid_o, data_out_r, data_out_i);
      end
      valid_i   = 1'($urandom_range(0, 1));
      data_in_r = 19'(rnd19());
      data_in_i = 19'(rnd19());
    end
    valid_i = 1'b0;
  endtask

  // Drives nfr gapless frames; a glen-cycle valid_i gap precedes global
  // sample gpos; reset is asserted in place of sample rst_at.
  task automatic run_frames(int nfr, int gpos, int glen, int rst_at, output int t0);
    t0 = 0;
    vcyc.delete();
    out_idx = 0;
    for (int f = 0; f < nfr; f++) model_push(32 * f);
    for (int s = 0; s < 32 * nfr; s++) begin
      if (s == rst_at) begin
        @(negedge clk);
        #1;
        rst = 1'b0;
        valid_i = 1'b0;
        return;
      end
      if (s == gpos) begin
        for (int c = 0; c < glen; c++) begin
          @(negedge clk);
          valid_i   = 1'b0;
          data_in_r = 19'(rnd19());
          data_in_i = 19'(rnd19());
        end
      end
      @(negedge clk);
      if (s == 0) t0 = cyc;
      valid_i   = 1'b1;
      data_in_r = 19'(fr_r[s]);
      data_in_i = 19'(fr_i[s]);
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_done(string name);
    int k;
    k = 0;
    while (exp_r.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (exp_r.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d outputs outstanding, required 0", name, exp_r.size());
      exp_r.delete();
      exp_i.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Output i is produced by step i+8 and seen one cycle after that step.
  task automatic check_timing(string name, int t0, int n, int gpos, int glen);
    int want;
    n_cmp++;
    if (vcyc.size() != n) begin
      n_bad++;
      $display("FAIL %s count: got %0d valid cycles, required %0d", name, vcyc.size(), n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      want = t0 + 9 + i + ((gpos >= 0 && i + 8 >= gpos) ? glen : 0);
      if (vcyc[i] != want) begin
        n_bad++;
        $display("FAIL %s idx=%0d: got cycle %0d, required cycle %0d", name, i, vcyc[i] - t0, want - t0);
        return;
      end
    end
  endtask

  task automatic check_val(string name, int idx, int r, int i);
    n_cmp++;
    if (got_r[idx] != r || got_i[idx] != i) begin
      n_bad++;
      $display("FAIL %s: got (%0d,%0d), required (%0d,%0d)", name, got_r[idx], got_i[idx], r, i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int nz;

    #1 rst = 1'b0;
    reset_quiet("reset_hold", 10);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Impulse at x0.
    clear_frames();
    fr_r[0] = 1000;
    run_frames(1, -1, 0, -1, t0);
    wait_done("impulse");
    check_timing("impulse_timing", t0, 32, -1, 0);
    check_val("impulse_out0", 0, 1000, 0);
    check_val("impulse_out8", 8, 1000, 0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      imp_r[i] = got_r[i];
      imp_i[i] = got_i[i];
      if (i != 0 && i != 8 && (got_r[i] != 0 || got_i[i] != 0)) nz++;
    end
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL impulse_zeros: got %0d nonzero outputs, required 0", nz);
    end

    // Twiddle k=1.
    clear_frames();
    fr_r[1] = 1000;
    run_frames(1, -1, 0, -1, t0);
    wait_done("twiddle_k1");
    check_val("twiddle_out1", 1, 1000, 0);
    check_val("twiddle_out9", 9, 926, -383);

    // Differences at every k with distinct values.
    clear_frames();
    for (int k = 0; k < 8; k++) begin
      fr_r[k]      = 500 * (k + 1);
      fr_i[k]      = -300 * (k + 1);
      fr_r[16 + k] = rnd19();
      fr_i[24 + k] = rnd19();
    end
    run_frames(1, -1, 0, -1, t0);
    wait_done("twiddle_all");

    // Saturation of the sum.
    clear_frames();
    fr_r[0] = 262143;  fr_i[0] = -262144;
    fr_r[8] = 262143;  fr_i[8] = -262144;
    run_frames(1, -1, 0, -1, t0);
    wait_done("saturation");
    check_val("sat_out0", 0, 262143, -262144);
    check_val("sat_out8", 8, 0, 0);

    // Isolated full-range random frames.
    for (int n = 0; n < 3; n++) begin
      for (int s = 0; s < 32; s++) begin
        fr_r[s] = rnd19();
        fr_i[s] = rnd19();
      end
      run_frames(1, -1, 0, -1, t0);
      wait_done("random");
      check_timing("random_timing", t0, 32, -1, 0);
    end

    // Back-to-back frames with a 3-cycle gap before sample 12 of frame 1.
    for (int s = 0; s < 64; s++) begin
      fr_r[s] = rnd19();
      fr_i[s] = rnd19();
    end
    run_frames(2, 12, 3, -1, t0);
    wait_done("b2b_stall");
    check_timing("b2b_stall_timing", t0, 64, 12, 3);

    // Reset in place of sample 20, then a fresh impulse frame.
    clear_frames();
    fr_r[0] = 1000;
    run_frames(1, -1, 0, 20, t0);
    exp_r.delete();
    exp_i.delete();
    check_timing("prereset_timing", t0, 12, -1, 0);
    reset_quiet("reset_midframe", 3);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    run_frames(1, -1, 0, -1, t0);
    wait_done("post_reset");
    check_timing("post_reset_timing", t0, 32, -1, 0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      if (got_r[i] != imp_r[i] || got_i[i] != imp_i[i]) nz++;
    end
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL post_reset_vs_impulse: got %0d differing outputs, required 0", nz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
